wb_io_bank: RTL and testbench
=============================

WB_IO_BANK -- requirements
Module: wb_io_bank

Interface
REQ-001 Parameter NUM_IO, default 38: number of IO channels; legal range 1..64.
REQ-002 Parameter BASE_ADDR, default 32'h3000_0000: Wishbone window base; bits [7:0] ignored.
REQ-003 Parameter IRQ_LINES, default 3: interrupt output count; legal range 1..3.
REQ-004 wb_clk_i  input  1  sole clock; all state on rising edge.
REQ-005 wb_rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-006 wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone classic slave controls.
REQ-007 wbs_adr_i  input  32  byte address; wbs_dat_i  input  32  write data; wbs_sel_i  input  4  byte enables.
REQ-008 wbs_ack_o  output  1  transfer acknowledge; wbs_dat_o  output  32  read data.
REQ-009 io_in  input  NUM_IO  pad inputs, asynchronous to wb_clk_i.
REQ-010 io_out  output  NUM_IO  pad output values; io_oeb  output  NUM_IO  pad output enables, active-low.
REQ-011 user_irq  output  IRQ_LINES  level interrupts.

Function
REQ-012 Select = cyc & stb & (adr[31:8] == BASE_ADDR[31:8]); unselected cycles get no ack and change no state.
REQ-013 Register map, word offset adr[7:2]: 0x00 OUT_LO, 0x04 OUT_HI, 0x08 OEB_LO, 0x0C OEB_HI, 0x10 IN_LO (RO), 0x14 IN_HI (RO), 0x18 IEN_LO, 0x1C IEN_HI, 0x20 STAT_LO (W1C), 0x24 STAT_HI (W1C), 0x28 EDGE_LO, 0x2C EDGE_HI; LO = channels 31:0, HI = channels 63:32.
REQ-014 Bits for channels >= NUM_IO read 0, ignore writes.
REQ-015 Offsets in window but not mapped: ack, read 0, writes ignored.
REQ-016 Ack: registered, asserted exactly one cycle after select is first sampled, held one cycle only; select still high in the ack cycle starts no new transfer; next transfer is accepted the cycle after ack drops (max one transfer per 2 cycles).
REQ-017 Writes commit at the edge that raises ack; byte lane n written only if wbs_sel_i[n].
REQ-018 Read data registered, valid in the ack cycle; wbs_dat_o = 0 outside ack cycles.
REQ-019 io_out/io_oeb driven directly from OUT/OEB registers; new value visible the cycle ack rises.
REQ-020 io_in passes a 2-flop synchronizer; IN reads the second stage (2-3 cycle latency).
REQ-021 Edge detect compares second stage to a third (previous) stage: EDGE bit 0 = rising, 1 = falling.
REQ-022 Detected edge sets STAT bit the following cycle, regardless of IEN.
REQ-023 W1C write clears STAT bits written 1; same-cycle edge and clear on a bit: set wins.
REQ-024 user_irq[k] = registered OR of (STAT & IEN) over channels c with c mod IRQ_LINES == k; one cycle after STAT/IEN change.
REQ-025 Writes to IN_LO/IN_HI: acked, ignored.

Reset
REQ-026 On wb_rst_ni low, asynchronously: io_out = 0, io_oeb = all 1, IEN = 0, STAT = 0, EDGE = 0, synchronizer/edge stages = 0, wbs_ack_o = 0, wbs_dat_o = 0, user_irq = 0.
REQ-027 Reset mid-transfer aborts it: no ack, no register update; first transfer after deassertion behaves per REQ-016.
REQ-028 Edges on io_in during the first 3 cycles after reset deassert whose prior stage is reset 0 count as rising edges (no masking).

Verification
REQ-029 Write 0xA5A5_A5A5 sel=4'b1111 to 0x3000_0000 -> ack one cycle later, single pulse; io_out[31:0]=0xA5A5_A5A5 in ack cycle; readback returns same.
REQ-030 NUM_IO=38: write 0xFFFF_FFFF to OEB_HI with sel=4'b0001 -> io_oeb[37:32]=6'h3F unchanged-default then write 0x0 -> io_oeb[37:32]=0; read OEB_HI -> 0x0000_0000, bits 31:6 always 0.
REQ-031 EDGE=0, IEN bit 4=1, io_in[4] 0->1 -> STAT_LO bit 4=1 within 4 cycles; user_irq[1]=1 (4 mod 3); W1C 0x10 -> STAT 0, user_irq[1]=0 one cycle later.
REQ-032 Rising edge on io_in[0] detected in same cycle as W1C of bit 0 -> STAT_LO bit 0 stays 1.
REQ-033 Access to 0x3000_0100 and to 0x2FFF_FF00 -> no ack; access to offset 0x40 -> ack, read 0.
REQ-034 Assert wb_rst_ni low during cycle after select -> no ack; all outputs at REQ-026 values immediately, io_oeb all 1.

Source files
------------

// File: rtl/wb_io_bank_if.sv
// Wishbone classic slave bus bundle for the IO bank.
interface wb_io_bank_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [3:0]  wbs_sel_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_io_bank.sv
// Wishbone-mapped GPIO bank: output/enable registers, synchronized inputs,
// per-channel edge detection with sticky status and grouped level interrupts.
module wb_io_bank #(
    parameter int          NUM_IO    = 38,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          IRQ_LINES = 3
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    wb_io_bank_if.slave          bus,
    input  logic [NUM_IO-1:0]    io_in,
    output logic [NUM_IO-1:0]    io_out,
    output logic [NUM_IO-1:0]    io_oeb,
    output logic [IRQ_LINES-1:0] user_irq
);

    // Channels that physically exist; everything above reads as zero.
    localparam logic [63:0] CH_MASK = (NUM_IO >= 64) ? {64{1'b1}}
                                                     : ((64'd1 << NUM_IO) - 64'd1);

    logic [63:0] out_q, oeb_q, ien_q, stat_q, edge_q;
    logic [63:0] sync1_q, sync2_q, sync3_q;
    logic        ack_q;
    logic [31:0] dat_q;
    logic [IRQ_LINES-1:0] irq_q;

    logic        sel, start, wr;
    logic [5:0]  word;
    logic [31:0] bmask;
    logic [63:0] wmask64, wdata64, io_in_ext, clr, det, rval, pend;
    logic [31:0] rdata;
    logic [IRQ_LINES-1:0] irq_next;
    logic        wr_out, wr_oeb, wr_ien, wr_stat, wr_edge;
    logic        unused_adr;

    assign unused_adr = ^bus.wbs_adr_i[1:0];

    // Decode the bus: a transfer starts only when selected and no ack is pending,
    // which limits the bank to one transfer every two cycles.
    always_comb begin
        sel     = bus.wbs_cyc_i & bus.wbs_stb_i &
                  (bus.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
        start   = sel & ~ack_q;
        wr      = start & bus.wbs_we_i;
        word    = bus.wbs_adr_i[7:2];
        bmask   = {{8{bus.wbs_sel_i[3]}}, {8{bus.wbs_sel_i[2]}},
                   {8{bus.wbs_sel_i[1]}}, {8{bus.wbs_sel_i[0]}}};
        wmask64 = word[0] ? {bmask, 32'h0} : {32'h0, bmask};
        wdata64 = {bus.wbs_dat_i, bus.wbs_dat_i};
        wr_out  = wr && (word[5:1] == 5'd0);
        wr_oeb  = wr && (word[5:1] == 5'd1);
        wr_ien  = wr && (word[5:1] == 5'd3);
        wr_stat = wr && (word[5:1] == 5'd4);
        wr_edge = wr && (word[5:1] == 5'd5);
        clr     = wr_stat ? (wdata64 & wmask64) : 64'h0;
    end

    // Zero-extend the pad inputs and detect the configured edge per channel.
    always_comb begin
        io_in_ext             = 64'h0;
        io_in_ext[NUM_IO-1:0] = io_in;
        det = ((~edge_q & sync2_q & ~sync3_q) | (edge_q & ~sync2_q & sync3_q)) & CH_MASK;
        pend = stat_q & ien_q;
    end

    // Read mux; unmapped offsets inside the window return zero.
    always_comb begin
        case (word[5:1])
            5'd0:    rval = out_q;
            5'd1:    rval = oeb_q;
            5'd2:    rval = sync2_q;
            5'd3:    rval = ien_q;
            5'd4:    rval = stat_q;
            5'd5:    rval = edge_q;
            default: rval = 64'h0;
        endcase
        rdata = word[0] ? rval[63:32] : rval[31:0];
    end

    // Fold pending channels onto interrupt lines by channel index modulo line count.
    always_comb begin
        irq_next = '0;
        for (int c = 0; c < 64; c++) begin
            if (c < NUM_IO) begin
                irq_next[c % IRQ_LINES] = irq_next[c % IRQ_LINES] | pend[c];
            end
        end
    end

    // Bus response: single-cycle registered ack, read data only during ack.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q <= 1'b0;
            dat_q <= 32'h0;
        end else begin
            ack_q <= start;
            dat_q <= (start && !bus.wbs_we_i) ? rdata : 32'h0;
        end
    end

    // Software-writable configuration registers with byte-lane enables.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            out_q  <= 64'h0;
            oeb_q  <= CH_MASK;
            ien_q  <= 64'h0;
            edge_q <= 64'h0;
        end else begin
            if (wr_out)  out_q  <= ((out_q  & ~wmask64) | (wdata64 & wmask64)) & CH_MASK;
            if (wr_oeb)  oeb_q  <= ((oeb_q  & ~wmask64) | (wdata64 & wmask64)) & CH_MASK;
            if (wr_ien)  ien_q  <= ((ien_q  & ~wmask64) | (wdata64 & wmask64)) & CH_MASK;
            if (wr_edge) edge_q <= ((edge_q & ~wmask64) | (wdata64 & wmask64)) & CH_MASK;
        end
    end

    // Input synchronizer, previous-sample stage and sticky status; a new edge
    // beats a simultaneous write-one-to-clear.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sync1_q <= 64'h0;
            sync2_q <= 64'h0;
            sync3_q <= 64'h0;
            stat_q  <= 64'h0;
        end else begin
            sync1_q <= io_in_ext;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            stat_q  <= ((stat_q & ~clr) | det) & CH_MASK;
        end
    end

    // Registered interrupt outputs.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            irq_q <= '0;
        end else begin
            irq_q <= irq_next;
        end
    end

    assign bus.wbs_ack_o = ack_q;
    assign bus.wbs_dat_o = dat_q;
    assign io_out        = out_q[NUM_IO-1:0];
    assign io_oeb        = oeb_q[NUM_IO-1:0];
    assign user_irq      = irq_q;

endmodule

// File: tb/tb_wb_io_bank.sv
// Directed testbench for wb_io_bank with hand-computed expected values.
module tb_wb_io_bank;

    localparam int NUM_IO    = 38;
    localparam int IRQ_LINES = 3;

    localparam logic [31:0] A_OUT_LO  = 32'h3000_0000;
    localparam logic [31:0] A_OUT_HI  = 32'h3000_0004;
    localparam logic [31:0] A_OEB_HI  = 32'h3000_000C;
    localparam logic [31:0] A_IN_LO   = 32'h3000_0010;
    localparam logic [31:0] A_IN_HI   = 32'h3000_0014;
    localparam logic [31:0] A_IEN_LO  = 32'h3000_0018;
    localparam logic [31:0] A_IEN_HI  = 32'h3000_001C;
    localparam logic [31:0] A_STAT_LO = 32'h3000_0020;
    localparam logic [31:0] A_STAT_HI = 32'h3000_0024;
    localparam logic [31:0] A_EDGE_LO = 32'h3000_0028;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_IO-1:0]    io_in;
    logic [NUM_IO-1:0]    io_out;
    logic [NUM_IO-1:0]    io_oeb;
    logic [IRQ_LINES-1:0] user_irq;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0]       rd;
    logic [NUM_IO-1:0] out_snap;

    always #5 clk = ~clk;

    wb_io_bank_if bus();

    wb_io_bank #(
        .NUM_IO    (NUM_IO),
        .BASE_ADDR (32'h3000_0000),
        .IRQ_LINES (IRQ_LINES)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .bus       (bus),
        .io_in     (io_in),
        .io_out    (io_out),
        .io_oeb    (io_oeb),
        .user_irq  (user_irq)
    );

    // Single comparison point: counts every vector and reports miscompares.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic busIdle();
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = 32'h0;
        bus.wbs_dat_i = 32'h0;
        bus.wbs_sel_i = 4'h0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One bus transfer driven from a falling edge; checks ack presence, that it
    // lasts one cycle, and that read data returns to zero afterwards.
    task automatic applyStimulus(input string tag, input logic we, input logic [31:0] adr,
                                 input logic [31:0] dat, input logic [3:0] sel,
                                 input logic exp_ack, output logic [31:0] rdata,
                                 output logic [NUM_IO-1:0] out_at_ack);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
        bus.wbs_sel_i = sel;
        @(negedge clk);
        checkOutput({tag, " ack"}, 64'(bus.wbs_ack_o), 64'(exp_ack));
        rdata      = bus.wbs_dat_o;
        out_at_ack = io_out;
        busIdle();
        @(negedge clk);
        checkOutput({tag, " ack drop"}, 64'(bus.wbs_ack_o), 64'h0);
        checkOutput({tag, " dat idle"}, 64'(bus.wbs_dat_o), 64'h0);
    endtask

    task automatic wbWrite(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
        logic [31:0]       r;
        logic [NUM_IO-1:0] o;
        applyStimulus(tag, 1'b1, adr, dat, sel, 1'b1, r, o);
    endtask

    task automatic wbReadCheck(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0]       r;
        logic [NUM_IO-1:0] o;
        applyStimulus(tag, 1'b0, adr, 32'h0, 4'hF, 1'b1, r, o);
        checkOutput({tag, " data"}, 64'(r), 64'(exp));
    endtask

    initial begin
        busIdle();
        io_in = '0;
        rst_n = 1'b0;

        // Reset state
        waitCycles(2);
        checkOutput("rst io_out", 64'(io_out), 64'h0);
        checkOutput("rst io_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
        checkOutput("rst irq", 64'(user_irq), 64'h0);
        checkOutput("rst ack", 64'(bus.wbs_ack_o), 64'h0);
        checkOutput("rst dat", 64'(bus.wbs_dat_o), 64'h0);
        rst_n = 1'b1;
        waitCycles(1);

        // Full-word write, output visible in the ack cycle, readback
        applyStimulus("out_lo wr", 1'b1, A_OUT_LO, 32'hA5A5_A5A5, 4'hF, 1'b1, rd, out_snap);
        checkOutput("io_out at ack", 64'(out_snap[31:0]), 64'hA5A5_A5A5);
        wbReadCheck("out_lo rd", A_OUT_LO, 32'hA5A5_A5A5);

        // Byte lanes and channels beyond NUM_IO
        wbWrite("out_lo bytes", A_OUT_LO, 32'h1234_5678, 4'b0101);
        wbReadCheck("out_lo bytes rd", A_OUT_LO, 32'hA534_A578);
        wbWrite("out_hi wr", A_OUT_HI, 32'hFFFF_FFFF, 4'hF);
        wbReadCheck("out_hi rd", A_OUT_HI, 32'h0000_003F);
        checkOutput("io_out hi", 64'(io_out[37:32]), 64'h3F);

        // Output enables in the upper word
        wbWrite("oeb_hi b0", A_OEB_HI, 32'hFFFF_FFFF, 4'b0001);
        checkOutput("io_oeb hi ones", 64'(io_oeb[37:32]), 64'h3F);
        wbWrite("oeb_hi zero", A_OEB_HI, 32'h0, 4'hF);
        checkOutput("io_oeb hi zero", 64'(io_oeb[37:32]), 64'h0);
        wbReadCheck("oeb_hi rd0", A_OEB_HI, 32'h0);
        wbWrite("oeb_hi c5", A_OEB_HI, 32'hFFFF_FFC5, 4'hF);
        wbReadCheck("oeb_hi rd5", A_OEB_HI, 32'h0000_0005);
        checkOutput("io_oeb hi 05", 64'(io_oeb[37:32]), 64'h05);

        // Synchronized inputs; edges set status regardless of enables
        io_in = 38'h2A_1234_5678;
        waitCycles(3);
        wbReadCheck("in_lo rd", A_IN_LO, 32'h1234_5678);
        wbReadCheck("in_hi rd", A_IN_HI, 32'h0000_002A);
        wbReadCheck("stat_lo edges", A_STAT_LO, 32'h1234_5678);
        wbReadCheck("stat_hi edges", A_STAT_HI, 32'h0000_002A);
        checkOutput("irq no ien", 64'(user_irq), 64'h0);
        wbWrite("in_lo wr ign", A_IN_LO, 32'hFFFF_FFFF, 4'hF);
        wbReadCheck("in_lo after wr", A_IN_LO, 32'h1234_5678);
        io_in = '0;
        waitCycles(4);
        wbReadCheck("stat_lo no fall", A_STAT_LO, 32'h1234_5678);
        wbWrite("stat_lo w1c all", A_STAT_LO, 32'hFFFF_FFFF, 4'hF);
        wbWrite("stat_hi w1c all", A_STAT_HI, 32'hFFFF_FFFF, 4'hF);
        wbReadCheck("stat_lo cleared", A_STAT_LO, 32'h0);
        wbReadCheck("stat_hi cleared", A_STAT_HI, 32'h0);

        // Rising edge on channel 4 raises interrupt line 1
        wbWrite("ien_lo wr", A_IEN_LO, 32'h0000_0010, 4'hF);
        wbReadCheck("ien_lo rd", A_IEN_LO, 32'h0000_0010);
        wbWrite("ien_hi wr", A_IEN_HI, 32'hFFFF_FFFF, 4'hF);
        wbReadCheck("ien_hi rd", A_IEN_HI, 32'h0000_003F);
        io_in[4] = 1'b1;
        waitCycles(4);
        checkOutput("irq rise ch4", 64'(user_irq), 64'h2);
        wbReadCheck("stat_lo ch4", A_STAT_LO, 32'h0000_0010);
        wbWrite("stat_lo w1c ch4", A_STAT_LO, 32'h0000_0010, 4'hF);
        checkOutput("irq after w1c", 64'(user_irq), 64'h0);
        wbReadCheck("stat_lo ch4 clr", A_STAT_LO, 32'h0);

        // Falling-edge mode on channel 4
        wbWrite("edge_lo wr", A_EDGE_LO, 32'h0000_0010, 4'hF);
        wbReadCheck("edge_lo rd", A_EDGE_LO, 32'h0000_0010);
        io_in[4] = 1'b0;
        waitCycles(4);
        checkOutput("irq fall ch4", 64'(user_irq), 64'h2);
        wbReadCheck("stat_lo fall", A_STAT_LO, 32'h0000_0010);
        wbWrite("stat_lo w1c fall", A_STAT_LO, 32'h0000_0010, 4'hF);
        wbWrite("edge_lo clr", A_EDGE_LO, 32'h0, 4'hF);
        checkOutput("irq fall clr", 64'(user_irq), 64'h0);

        // Edge and clear on the same bit in the same cycle: the edge wins
        io_in[0] = 1'b1;
        waitCycles(2);
        wbWrite("stat_lo w1c race", A_STAT_LO, 32'h0000_0001, 4'hF);
        wbReadCheck("stat_lo race", A_STAT_LO, 32'h0000_0001);
        wbWrite("ien_lo ch0", A_IEN_LO, 32'h0000_0011, 4'hF);
        checkOutput("irq ch0", 64'(user_irq), 64'h1);

        // Address decode
        applyStimulus("above window", 1'b1, 32'h3000_0100, 32'hDEAD_BEEF, 4'hF, 1'b0, rd, out_snap);
        applyStimulus("below window", 1'b0, 32'h2FFF_FF00, 32'h0, 4'hF, 1'b0, rd, out_snap);
        checkOutput("below window dat", 64'(rd), 64'h0);
        wbReadCheck("out_lo no alias", A_OUT_LO, 32'hA534_A578);
        wbWrite("unmapped wr", 32'h3000_0040, 32'hFFFF_FFFF, 4'hF);
        wbReadCheck("unmapped rd", 32'h3000_0040, 32'h0);
        wbReadCheck("out_lo after unmapped", A_OUT_LO, 32'hA534_A578);

        // Select held high: ack pattern 1,0,1
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = A_OUT_LO;
        bus.wbs_sel_i = 4'hF;
        @(negedge clk);
        checkOutput("held ack1", 64'(bus.wbs_ack_o), 64'h1);
        checkOutput("held dat1", 64'(bus.wbs_dat_o), 64'hA534_A578);
        @(negedge clk);
        checkOutput("held gap", 64'(bus.wbs_ack_o), 64'h0);
        @(negedge clk);
        checkOutput("held ack2", 64'(bus.wbs_ack_o), 64'h1);
        busIdle();
        @(negedge clk);
        checkOutput("held drop", 64'(bus.wbs_ack_o), 64'h0);

        // Reset in the middle of a transfer
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b1;
        bus.wbs_adr_i = A_OUT_LO;
        bus.wbs_dat_i = 32'h1111_1111;
        bus.wbs_sel_i = 4'hF;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid rst ack", 64'(bus.wbs_ack_o), 64'h0);
        checkOutput("mid rst io_out", 64'(io_out), 64'h0);
        checkOutput("mid rst io_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
        checkOutput("mid rst irq", 64'(user_irq), 64'h0);
        checkOutput("mid rst dat", 64'(bus.wbs_dat_o), 64'h0);
        @(negedge clk);
        checkOutput("mid rst ack held", 64'(bus.wbs_ack_o), 64'h0);
        busIdle();
        rst_n = 1'b1;
        waitCycles(4);
        wbReadCheck("post rst out_lo", A_OUT_LO, 32'h0);
        wbReadCheck("post rst stat edge", A_STAT_LO, 32'h0000_0001);
        checkOutput("post rst irq", 64'(user_irq), 64'h0);
        applyStimulus("post rst wr", 1'b1, A_OUT_LO, 32'h5A5A_5A5A, 4'hF, 1'b1, rd, out_snap);
        checkOutput("post rst io_out", 64'(out_snap[31:0]), 64'h5A5A_5A5A);
        wbReadCheck("post rst rd", A_OUT_LO, 32'h5A5A_5A5A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
